// File: rtl/mux_seq_pkg.sv
// Shared opcodes, FSM encoding and field layout
// for the MUX instruction sequencer.
package mux_seq_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;
  localparam int ARG_W  = 24;

  typedef enum logic [1:0] {
    OP_ISSUE     = 2'b00,
    OP_DELAY     = 2'b01,
    OP_WAIT_DATA = 2'b10,
    OP_END       = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_IDLE,
    S_DELAY,
    S_WAIT_DATA
  } state_e;

  function automatic logic [ARG_W-1:0] min_one(
    input logic [ARG_W-1:0] a
  );
    return (a == '0) ? ARG_W'(1) : a;
  endfunction

endpackage

// File: rtl/mux_seq_if.sv
// Instruction FIFO and MUX-side signals of the sequencer.
// Directions are named from the sequencer's point of view.
interface mux_seq_if;

  logic                         ins_empty_i;
  logic [31:0]                  ins_data_i;
  logic                         ins_rd_o;
  logic                         mux_en_o;
  logic [mux_seq_pkg::ARG_W-1:0] mux_ins_o;
  logic                         mux_idle_i;
  logic                         mux_data_ready_i;

  modport master (
    input  ins_empty_i,
    input  ins_data_i,
    input  mux_idle_i,
    input  mux_data_ready_i,
    output ins_rd_o,
    output mux_en_o,
    output mux_ins_o
  );

  modport slave (
    output ins_empty_i,
    output ins_data_i,
    output mux_idle_i,
    output mux_data_ready_i,
    input  ins_rd_o,
    input  mux_en_o,
    input  mux_ins_o
  );

endinterface

// File: rtl/seq_timer.sv
// Delay down-counter plus wait-timeout up-counter,
// shared by DELAY and the WAIT_IDLE/WAIT_DATA timeouts.
module seq_timer #(
  parameter int          W_DELAY = 24,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dn_load_i,
  input  logic [W_DELAY-1:0] dn_val_i,
  input  logic               dn_dec_i,
  output logic [W_DELAY-1:0] dn_cnt_o,
  input  logic               up_clr_i,
  input  logic               up_inc_i,
  output logic               up_hit_o
);

  logic [W_DELAY-1:0] dn_q, dn_d;
  logic [15:0]        up_q, up_d;

  always_comb begin
    dn_d = dn_q;
    if (dn_load_i) begin
      dn_d = dn_val_i;
    end else if (dn_dec_i && dn_q != '0) begin
      dn_d = dn_q - W_DELAY'(1);
    end
  end

  always_comb begin
    up_d = up_q;
    if (up_clr_i) begin
      up_d = '0;
    end else if (up_inc_i) begin
      up_d = up_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dn_q <= '0;
      up_q <= '0;
    end else begin
      dn_q <= dn_d;
      up_q <= up_d;
    end
  end

  assign dn_cnt_o = dn_q;
  // Hit on the cycle that completes TIMEOUT waiting cycles.
  assign up_hit_o = (up_q + 16'd1) == TIMEOUT;

endmodule

// File: rtl/mux_sequencer.sv
// Pops program words from the host FIFO and issues MUX
// instructions, gated on MUX idle, with delays and data waits.
module mux_sequencer
  import mux_seq_pkg::*;
#(
  parameter int          W_DELAY = 24,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic      fpga_clk_i,
  input  logic      reset_n_i,
  input  logic      start_i,
  input  logic      abort_i,
  mux_seq_if.master bus,
  output logic      busy_o,
  output logic      done_o,
  output logic      timeout_o
);

  state_e             state_q, state_d;
  logic [ARG_W-1:0]   ins_q, ins_d;
  logic               pend_q, pend_d;
  logic               tmo_q, tmo_d;

  op_e                op;
  logic [ARG_W-1:0]   arg;
  logic               rd, en, done;
  logic               dn_load, dn_dec;
  logic               up_clr, up_inc, up_hit;
  logic [W_DELAY-1:0] dn_cnt;
  logic               unused_rsvd;

  assign op  = op_e'(bus.ins_data_i[OP_MSB:OP_LSB]);
  assign arg = bus.ins_data_i[ARG_W-1:0];
  assign unused_rsvd = ^bus.ins_data_i[29:24];

  seq_timer #(
    .W_DELAY (W_DELAY),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (fpga_clk_i),
    .rst_ni    (reset_n_i),
    .dn_load_i (dn_load),
    .dn_val_i  (W_DELAY'(min_one(arg))),
    .dn_dec_i  (dn_dec),
    .dn_cnt_o  (dn_cnt),
    .up_clr_i  (up_clr),
    .up_inc_i  (up_inc),
    .up_hit_o  (up_hit)
  );

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    rd      = 1'b0;
    en      = 1'b0;
    done    = 1'b0;
    dn_load = 1'b0;
    dn_dec  = 1'b0;
    up_clr  = 1'b0;
    up_inc  = 1'b0;

    if (state_q != S_IDLE && bus.mux_data_ready_i) begin
      pend_d = 1'b1;
    end

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_FETCH;
            tmo_d   = 1'b0;
            pend_d  = 1'b0;
          end
        end
        S_FETCH: begin
          if (!bus.ins_empty_i) begin
            rd = 1'b1;
            unique case (op)
              OP_ISSUE: begin
                ins_d   = arg;
                state_d = S_ISSUE;
              end
              OP_DELAY: begin
                dn_load = 1'b1;
                state_d = S_DELAY;
              end
              OP_WAIT_DATA: begin
                up_clr  = 1'b1;
                state_d = S_WAIT_DATA;
              end
              OP_END: begin
                done    = 1'b1;
                state_d = S_IDLE;
              end
            endcase
          end
        end
        S_ISSUE: begin
          en      = 1'b1;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          up_clr  = 1'b1;
          state_d = S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (bus.mux_idle_i) begin
            state_d = S_FETCH;
          end else if (up_hit) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            up_inc = 1'b1;
          end
        end
        S_DELAY: begin
          dn_dec = 1'b1;
          // Leave as the count steps down to 1.
          if (dn_cnt <= W_DELAY'(2)) begin
            state_d = S_FETCH;
          end
        end
        S_WAIT_DATA: begin
          if (pend_q || bus.mux_data_ready_i) begin
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end else if (up_hit) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            up_inc = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      ins_q   <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.ins_rd_o  = rd;
  assign bus.mux_en_o  = en;
  assign bus.mux_ins_o = ins_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done;
  assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed bench for mux_sequencer: program table
// plus hand sequences for timeout, abort and reset.
module tb_mux_sequencer;
  import mux_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort;
  logic busy, done, tmo;

  mux_seq_if bus();

  mux_sequencer #(
    .TIMEOUT (16'd16)
  ) dut (
    .fpga_clk_i (clk),
    .reset_n_i  (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .timeout_o  (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.ins_empty_i = (rd_ptr == wr_ptr);
  assign bus.ins_data_i  = mem[rd_ptr % 16];

  always @(posedge clk) begin
    if (bus.ins_rd_o) rd_ptr <= rd_ptr + 1;
  end

  int cyc = 0;
  int en_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int en_log [64];
  int pop_log [64];
  int done_cyc = 0;
  int b2b = 0;
  bit rd_prev = 0;
  bit hold0 = 0, drop_mode = 0, ready_on_en = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mux_en_o) begin
      en_log[en_cnt % 64] = cyc;
      en_cnt = en_cnt + 1;
    end
    if (bus.ins_rd_o) begin
      pop_log[pop_cnt % 64] = cyc;
      pop_cnt = pop_cnt + 1;
      if (rd_prev) b2b = b2b + 1;
    end
    rd_prev = bus.ins_rd_o;
    if (done) begin
      done_cyc = cyc;
      done_cnt = done_cnt + 1;
    end
    bus.mux_idle_i = !(hold0 || (drop_mode && en_cnt > 0 &&
      cyc >= en_log[(en_cnt-1) % 64] + 2 &&
      cyc <= en_log[(en_cnt-1) % 64] + 6));
    bus.mux_data_ready_i = ready_on_en && bus.mux_en_o;
  end

  typedef struct {
    logic [31:0] w0, w1, w2;
    int          n;
    bit          drop;
    bit          rdy;
    int          en_n;
    logic [23:0] ins;
    int          pops;
    int          lat;
    int          dlat;
    int          gap;
  } vec_t;

  localparam int NV = 8;
  vec_t v [NV];

  function automatic logic [31:0] mkw(op_e op, logic [23:0] a);
    return {op, 6'h00, a};
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_quiet(string name);
    for (int k = 0; k < 300 && busy; k++) tick();
    chk(name, {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_en(string name);
    for (int k = 0; k < 50 && !bus.mux_en_o; k++) tick();
    chk(name, {31'b0, bus.mux_en_o}, 32'h1);
  endtask

  int en0, p0, d0;

  initial begin
    v[0] = '{mkw(OP_ISSUE, 24'h900155), mkw(OP_END, 0), 0,
             2, 1, 0, 1, 24'h900155, 2, 1, 8, 0};
    v[1] = '{mkw(OP_DELAY, 24'd10), mkw(OP_ISSUE, 24'h123456),
             mkw(OP_END, 0), 3, 0, 0, 1, 24'h123456, 3, 11, 3, 0};
    v[2] = '{mkw(OP_DELAY, 24'd0), mkw(OP_ISSUE, 24'h0ABCDE),
             mkw(OP_END, 0), 3, 0, 0, 1, 24'h0ABCDE, 3, 3, 3, 0};
    v[3] = '{mkw(OP_DELAY, 24'd1), mkw(OP_ISSUE, 24'h0FEDCB),
             mkw(OP_END, 0), 3, 0, 0, 1, 24'h0FEDCB, 3, 3, 3, 0};
    v[4] = '{mkw(OP_ISSUE, 24'h0C0003), mkw(OP_WAIT_DATA, 0),
             mkw(OP_END, 0), 3, 0, 1, 1, 24'h0C0003, 3, 1, 5, 0};
    v[5] = '{mkw(OP_ISSUE, 24'h111111), mkw(OP_ISSUE, 24'h222222),
             mkw(OP_END, 0), 3, 0, 0, 2, 24'h222222, 3, 1, 3, 4};
    v[6] = '{mkw(OP_END, 0), 0, 0,
             1, 0, 0, 0, 24'h222222, 1, -1, -1, 0};
    v[7] = '{32'h3FABCDEF, mkw(OP_END, 0), 0,
             2, 0, 0, 1, 24'hABCDEF, 2, 1, 3, 0};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ins", {8'b0, bus.mux_ins_o}, 32'h0);
    chk("rst_en", {31'b0, bus.mux_en_o}, 32'h0);
    chk("rst_tmo", {31'b0, tmo}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      en0 = en_cnt;
      p0  = pop_cnt;
      d0  = done_cnt;
      push(v[i].w0);
      if (v[i].n > 1) push(v[i].w1);
      if (v[i].n > 2) push(v[i].w2);
      drop_mode   = v[i].drop;
      ready_on_en = v[i].rdy;
      pulse_start();
      wait_quiet($sformatf("v%0d_quiet", i));
      repeat (2) tick();
      chk($sformatf("v%0d_en_n", i), en_cnt - en0, v[i].en_n);
      chk($sformatf("v%0d_ins", i), {8'b0, bus.mux_ins_o},
          {8'b0, v[i].ins});
      chk($sformatf("v%0d_pops", i), pop_cnt - p0, v[i].pops);
      chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_tmo", i), {31'b0, tmo}, 32'h0);
      if (v[i].lat >= 0 && en_cnt > en0)
        chk($sformatf("v%0d_lat", i),
            en_log[en0 % 64] - pop_log[p0 % 64], v[i].lat);
      if (v[i].dlat >= 0 && en_cnt > en0)
        chk($sformatf("v%0d_dlat", i),
            done_cyc - en_log[(en_cnt-1) % 64], v[i].dlat);
      if (v[i].en_n == 2 && en_cnt - en0 == 2)
        chk($sformatf("v%0d_gap", i),
            en_log[(en0+1) % 64] - en_log[en0 % 64], v[i].gap);
      flush();
    end
    drop_mode   = 0;
    ready_on_en = 0;

    // Timeout while MUX never returns idle
    en0 = en_cnt; p0 = pop_cnt; d0 = done_cnt;
    hold0 = 1;
    push(mkw(OP_ISSUE, 24'h00ABCD));
    push(mkw(OP_END, 0));
    pulse_start();
    wait_en("to_en");
    repeat (17) tick();
    chk("to_pre_tmo", {31'b0, tmo}, 32'h0);
    chk("to_pre_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("to_tmo", {31'b0, tmo}, 32'h1);
    chk("to_busy", {31'b0, busy}, 32'h0);
    repeat (3) tick();
    chk("to_sticky", {31'b0, tmo}, 32'h1);
    chk("to_pops", pop_cnt - p0, 1);
    chk("to_left", {31'b0, bus.ins_empty_i}, 32'h0);
    chk("to_nodone", done_cnt - d0, 0);
    hold0 = 0;
    pulse_start();
    chk("to_clear", {31'b0, tmo}, 32'h0);
    wait_quiet("to_quiet");
    repeat (2) tick();
    chk("to_done", done_cnt - d0, 1);
    chk("to_pops2", pop_cnt - p0, 2);
    flush();

    // Abort in the middle of a DELAY
    en0 = en_cnt; p0 = pop_cnt; d0 = done_cnt;
    push(mkw(OP_DELAY, 24'd20));
    push(mkw(OP_ISSUE, 24'h777777));
    push(mkw(OP_END, 0));
    pulse_start();
    repeat (3) tick();
    chk("ab_busy", {31'b0, busy}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle", {31'b0, busy}, 32'h0);
    repeat (25) tick();
    chk("ab_en", en_cnt - en0, 0);
    chk("ab_pops", pop_cnt - p0, 1);
    chk("ab_done", done_cnt - d0, 0);
    chk("ab_still", {31'b0, busy}, 32'h0);
    flush();

    // Abort together with start in IDLE
    p0 = pop_cnt; d0 = done_cnt;
    push(mkw(OP_END, 0));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("as_busy", {31'b0, busy}, 32'h0);
    repeat (3) tick();
    chk("as_pops", pop_cnt - p0, 0);
    chk("as_done", done_cnt - d0, 0);
    chk("as_busy2", {31'b0, busy}, 32'h0);
    flush();

    // Asynchronous reset during WAIT_IDLE
    p0 = pop_cnt;
    hold0 = 1;
    push(mkw(OP_ISSUE, 24'h5A5A5A));
    push(mkw(OP_END, 0));
    pulse_start();
    wait_en("rs_en");
    repeat (3) tick();
    chk("rs_busy_pre", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", {31'b0, busy}, 32'h0);
    chk("rs_ins", {8'b0, bus.mux_ins_o}, 32'h0);
    chk("rs_en0", {31'b0, bus.mux_en_o}, 32'h0);
    chk("rs_rd", {31'b0, bus.ins_rd_o}, 32'h0);
    chk("rs_done", {31'b0, done}, 32'h0);
    chk("rs_tmo", {31'b0, tmo}, 32'h0);
    hold0 = 0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rs_stay", {31'b0, busy}, 32'h0);
    chk("rs_pops", pop_cnt - p0, 1);
    flush();

    chk("no_b2b_pops", b2b, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
